// File: rtl/ddr_wr_arb.sv
// Four-channel round-robin write arbiter in front of a single DDR write controller.
// Optional watchdog on the data phase is enabled with `define ARB_TIMEOUT_EN.
module ddr_wr_arb #(
   parameter int ADDR_WIDTH     = 27,
   parameter int LEN_WIDTH      = 16,
   parameter int DQ_WIDTH       = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                        ddr_clk,
   input  logic                        ddr_rst,
   input  logic [3:0]                  ch_wreq,
   input  logic [4*ADDR_WIDTH-1:0]     ch_waddr,
   input  logic [4*LEN_WIDTH-1:0]      ch_wr_len,
   input  logic [4*8*DQ_WIDTH-1:0]     ch_wdata,
   output logic [3:0]                  ch_wrdy,
   output logic [3:0]                  ch_wdata_req,
   output logic [3:0]                  ch_wdone,
   output logic                        m_wreq,
   output logic [ADDR_WIDTH-1:0]       m_waddr,
   output logic [LEN_WIDTH-1:0]        m_wr_len,
   input  logic                        m_wrdy,
   input  logic                        m_wdata_req,
   input  logic                        m_wdone,
   output logic [8*DQ_WIDTH-1:0]       m_wdata,
   output logic [1:0]                  grant_ch,
   output logic                        arb_busy,
   output logic                        timeout_err
);

   localparam int DW = 8 * DQ_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t     state;
   state_t     next_state;
   logic [1:0] sel_ch;
   logic       sel_found;
   logic [3:0] grant_oh;
   logic       to_hit;

   assign grant_oh = 4'b0001 << grant_ch;
   assign m_wdata  = ch_wdata[grant_ch*DW +: DW];
   assign arb_busy = (state != IDLE);

   // Round-robin pick: scan from the channel after the last grant.
   always_comb begin
      sel_ch    = grant_ch;
      sel_found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         if (!sel_found && ch_wreq[grant_ch + 2'(i)]) begin
            sel_found = 1'b1;
            sel_ch    = grant_ch + 2'(i);
         end
      end
   end

   // Next-state and handshake forwarding to the granted channel.
   always_comb begin
      next_state   = state;
      m_wreq       = 1'b0;
      ch_wrdy      = 4'b0000;
      ch_wdata_req = 4'b0000;
      ch_wdone     = 4'b0000;
      case (state)
         IDLE: begin
            if (sel_found) next_state = REQ;
         end
         REQ: begin
            m_wreq  = 1'b1;
            ch_wrdy = m_wrdy ? grant_oh : 4'b0000;
            if (m_wrdy) next_state = DATA;
         end
         DATA: begin
            ch_wdata_req = m_wdata_req ? grant_oh : 4'b0000;
            ch_wdone     = m_wdone ? grant_oh : 4'b0000;
            if (m_wdone || to_hit) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge ddr_clk or posedge ddr_rst) begin
      if (ddr_rst) state <= IDLE;
      else         state <= next_state;
   end

   // Latch the burst descriptor and winner at grant time.
   always_ff @(posedge ddr_clk or posedge ddr_rst) begin
      if (ddr_rst) begin
         grant_ch <= 2'd3;
         m_waddr  <= '0;
         m_wr_len <= '0;
      end else if (state == IDLE && sel_found) begin
         grant_ch <= sel_ch;
         m_waddr  <= ch_waddr[sel_ch*ADDR_WIDTH +: ADDR_WIDTH];
         m_wr_len <= ch_wr_len[sel_ch*LEN_WIDTH +: LEN_WIDTH];
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] to_cnt;

   assign to_hit = (state == DATA) && !m_wdone &&
                   (to_cnt == CW'(TIMEOUT_CYCLES - 1));

   // Data-phase watchdog; error flag is sticky until reset.
   always_ff @(posedge ddr_clk or posedge ddr_rst) begin
      if (ddr_rst) begin
         to_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == REQ && m_wrdy) to_cnt <= '0;
         else if (state == DATA)     to_cnt <= to_cnt + 1'b1;
         if (to_hit) timeout_err <= 1'b1;
      end
   end
`else
   assign to_hit      = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_wr_arb.sv
// Directed self-checking bench for ddr_wr_arb (default parameters).
// Inputs change and outputs are sampled 1-2 time units after the rising edge.
module tb_ddr_wr_arb;

   localparam int AW = 27;
   localparam int LW = 16;
   localparam int DW = 128;

   logic            ddr_clk = 1'b0;
   logic            ddr_rst;
   logic [3:0]      ch_wreq;
   logic [4*AW-1:0] ch_waddr;
   logic [4*LW-1:0] ch_wr_len;
   logic [4*DW-1:0] ch_wdata;
   logic [3:0]      ch_wrdy;
   logic [3:0]      ch_wdata_req;
   logic [3:0]      ch_wdone;
   logic            m_wreq;
   logic [AW-1:0]   m_waddr;
   logic [LW-1:0]   m_wr_len;
   logic            m_wrdy;
   logic            m_wdata_req;
   logic            m_wdone;
   logic [DW-1:0]   m_wdata;
   logic [1:0]      grant_ch;
   logic            arb_busy;
   logic            timeout_err;

   int checks   = 0;
   int failures = 0;

   ddr_wr_arb dut (
      .ddr_clk      (ddr_clk),
      .ddr_rst      (ddr_rst),
      .ch_wreq      (ch_wreq),
      .ch_waddr     (ch_waddr),
      .ch_wr_len    (ch_wr_len),
      .ch_wdata     (ch_wdata),
      .ch_wrdy      (ch_wrdy),
      .ch_wdata_req (ch_wdata_req),
      .ch_wdone     (ch_wdone),
      .m_wreq       (m_wreq),
      .m_waddr      (m_waddr),
      .m_wr_len     (m_wr_len),
      .m_wrdy       (m_wrdy),
      .m_wdata_req  (m_wdata_req),
      .m_wdone      (m_wdone),
      .m_wdata      (m_wdata),
      .grant_ch     (grant_ch),
      .arb_busy     (arb_busy),
      .timeout_err  (timeout_err)
   );

   always #5 ddr_clk = ~ddr_clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ddr_clk);
      #1;
   endtask

   function automatic logic [AW-1:0] exp_addr(input int n);
      return AW'(32'h100 + n * 32'h40);
   endfunction

   function automatic logic [LW-1:0] exp_len(input int n);
      return LW'(160 + n);
   endfunction

   function automatic logic [DW-1:0] exp_data(input int n);
      return {16{8'(8'hA0 + n)}};
   endfunction

   task automatic wait_req();
      int k;
      k = 0;
      while (m_wreq !== 1'b1 && k < 8) begin
         tick();
         k++;
      end
      chk("wait_m_wreq", DW'(m_wreq), DW'(1));
   endtask

   // One complete burst expected on channel n.
   task automatic burst(input int n);
      logic [3:0] oh;
      oh = 4'b0001 << n;
      wait_req();
      chk("grant_ch", DW'(grant_ch), DW'(n));
      chk("m_waddr", DW'(m_waddr), DW'(exp_addr(n)));
      chk("m_wr_len", DW'(m_wr_len), DW'(exp_len(n)));
      chk("busy_req", DW'(arb_busy), DW'(1));
      m_wdone = 1'b1;
      #1 chk("wdone_in_req", DW'(ch_wdone), DW'(0));
      tick();
      m_wdone = 1'b0;
      chk("still_req", DW'(m_wreq), DW'(1));
      m_wrdy = 1'b1;
      #1 chk("ch_wrdy", DW'(ch_wrdy), DW'(oh));
      tick();
      m_wrdy = 1'b0;
      chk("m_wreq_off", DW'(m_wreq), DW'(0));
      chk("busy_data", DW'(arb_busy), DW'(1));
      m_wdata_req = 1'b1;
      #1 chk("ch_wdata_req", DW'(ch_wdata_req), DW'(oh));
      chk("m_wdata", m_wdata, exp_data(n));
      m_wdone = 1'b1;
      #1 chk("ch_wdone", DW'(ch_wdone), DW'(oh));
      chk("wdata_req_dn", DW'(ch_wdata_req), DW'(oh));
      tick();
      m_wdone     = 1'b0;
      m_wdata_req = 1'b0;
      #1 chk("idle_after", DW'(arb_busy), DW'(0));
      chk("wdone_pulse", DW'(ch_wdone), DW'(0));
   endtask

   initial begin
      ddr_rst     = 1'b1;
      ch_wreq     = 4'b0000;
      m_wrdy      = 1'b0;
      m_wdata_req = 1'b0;
      m_wdone     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ch_waddr[i*AW +: AW]  = exp_addr(i);
         ch_wr_len[i*LW +: LW] = exp_len(i);
         ch_wdata[i*DW +: DW]  = exp_data(i);
      end
      #12;
      chk("rst_grant", DW'(grant_ch), DW'(3));
      chk("rst_busy", DW'(arb_busy), DW'(0));
      chk("rst_mwreq", DW'(m_wreq), DW'(0));
      chk("rst_addr", DW'(m_waddr), DW'(0));
      chk("rst_len", DW'(m_wr_len), DW'(0));
      chk("rst_ch", DW'({ch_wrdy, ch_wdata_req, ch_wdone}), DW'(0));
      chk("rst_to", DW'(timeout_err), DW'(0));
      tick();
      ddr_rst = 1'b0;
      tick();

      // Single request on channel 0.
      ch_wreq = 4'b0001;
      tick();
      chk("c0_wreq", DW'(m_wreq), DW'(1));
      chk("c0_addr", DW'(m_waddr), DW'(32'h100));
      chk("c0_len", DW'(m_wr_len), DW'(160));
      m_wrdy = 1'b1;
      #1 chk("c0_wrdy", DW'(ch_wrdy), DW'(4'b0001));
      tick();
      m_wrdy = 1'b0;
      m_wdata_req = 1'b1;
      #1 chk("c0_dreq", DW'(ch_wdata_req), DW'(4'b0001));
      ch_wreq = 4'b0000;
      tick();
      m_wdata_req = 1'b0;
      chk("c0_hold", DW'(arb_busy), DW'(1));
      chk("c0_desc", DW'(m_waddr), DW'(32'h100));
      m_wdone = 1'b1;
      #1 chk("c0_wdone", DW'(ch_wdone), DW'(4'b0001));
      tick();
      m_wdone = 1'b0;
      chk("c0_idle", DW'(arb_busy), DW'(0));

      // Reset in the middle of a data phase on channel 1.
      ch_wreq = 4'b0010;
      wait_req();
      chk("c1_grant", DW'(grant_ch), DW'(1));
      m_wrdy = 1'b1;
      tick();
      m_wrdy = 1'b0;
      for (int i = 0; i < 10; i++) begin
         m_wdata_req = 1'b1;
         #1 chk("c1_dreq", DW'(ch_wdata_req), DW'(4'b0010));
         tick();
         m_wdata_req = 1'b0;
         tick();
      end
      ch_wreq = 4'b0000;
      m_wdone = 1'b1;
      ddr_rst = 1'b1;
      #1 chk("mrst_ch", DW'({ch_wrdy, ch_wdata_req, ch_wdone}), DW'(0));
      chk("mrst_busy", DW'(arb_busy), DW'(0));
      chk("mrst_grant", DW'(grant_ch), DW'(3));
      chk("mrst_desc", DW'({m_wreq, m_waddr, m_wr_len}), DW'(0));
      m_wdone = 1'b0;
      tick();
      ddr_rst = 1'b0;
      tick();

      // All channels requesting: strict rotation starting at 0.
      ch_wreq = 4'b1111;
      burst(0);
      burst(1);
      burst(2);
      burst(3);
      burst(0);

      // Channels 0 and 2 after channel 0 served.
      ch_wreq = 4'b0101;
      burst(2);
      burst(0);

      // Without the watchdog the data phase waits indefinitely.
      ch_wreq = 4'b0001;
      wait_req();
      ch_wreq = 4'b0000;
      m_wrdy = 1'b1;
      tick();
      m_wrdy = 1'b0;
      for (int i = 0; i < 40; i++) tick();
      chk("nodone_busy", DW'(arb_busy), DW'(1));
      chk("nodone_to", DW'(timeout_err), DW'(0));
      m_wdone = 1'b1;
      #1 chk("late_wdone", DW'(ch_wdone), DW'(4'b0001));
      tick();
      m_wdone = 1'b0;
      chk("late_idle", DW'(arb_busy), DW'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

endmodule
